serial_gate_nor: RTL

- Bit-serial counterpart of the parallel NOR array. Area-minimal: one gate_nor instance, time-multiplexed.
- Accepts two 2**S-bit operand words through a valid/ready handshake.
- Shifts the words LSB-first through the single gate_nor, one bit per clock, and reassembles the 2**S-bit result.
- Presents the result on an output valid/ready handshake. Sits between word-level producers and consumers where gate count matters more than throughput.

---
 rtl/serial_gate_nor_pkg.sv | 20 ++
 rtl/serial_gate_nor_gate_nor.sv | 10 +
 rtl/serial_gate_nor.sv | 106 ++++++++++
 3 files changed

// File: rtl/serial_gate_nor_pkg.sv
// Shared definitions for the bit-serial NOR block: state encoding and
// width helpers derived from the log2 word-width parameter.
package serial_gate_nor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int word_width(input int s);
    return 1 << s;
  endfunction

  // A one-bit word still needs a one-bit counter to keep the port legal.
  function automatic int cnt_width(input int s);
    return (s == 0) ? 1 : s;
  endfunction

endpackage

// File: rtl/serial_gate_nor_gate_nor.sv
// Single-bit NOR primitive; the serial block time-multiplexes one instance.
module gate_nor (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = ~(a | b);

endmodule

// File: rtl/serial_gate_nor.sv
// Bit-serial NOR: captures two W-bit words, pushes them LSB-first through one
// gate_nor and reassembles the W-bit result behind a valid/ready output.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; in_ready/out_valid never depend combinationally on
// in_valid/out_ready, and both are forced low while reset is high.
module serial_gate_nor
  import serial_gate_nor_pkg::*;
#(
  parameter int S = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [word_width(S)-1:0] in1,
  input  logic [word_width(S)-1:0] in2,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [word_width(S)-1:0] out,
  output logic                     busy
);

  localparam int W  = word_width(S);
  localparam int CW = cnt_width(S);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  r_q, r_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          nor_bit;

  gate_nor u_gate_nor (
    .a (a_q[0]),
    .b (b_q[0]),
    .y (nor_bit)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    r_d       = r_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = !reset;
        if (in_valid) begin
          a_d     = in1;
          b_d     = in2;
          r_d     = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        busy = !reset;
        a_d  = a_q >> 1;
        b_d  = b_q >> 1;
        // New bit enters at the MSB so the LSB computed first ends up at bit 0.
        r_d        = r_q >> 1;
        r_d[W-1]   = nor_bit;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        out_valid = !reset;
        busy      = !reset;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out = r_q;

endmodule
